// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises NUM_CH independent 1/2/4-byte read/write requests
// onto a single 8-bit RAM/IO port. Multi-byte reads are assembled and
// multi-byte writes are split, little-endian. Channel 0 has the highest
// fixed priority unless the MEM_ARB_RR_EN macro is defined, which selects
// round-robin arbitration. Both modes have identical latency.
module mem_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int CH_W       = 1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH-1:0]            req_wr,
    input  logic [2*NUM_CH-1:0]          req_size,
    input  logic [ADDR_WIDTH*NUM_CH-1:0] req_addr,
    input  logic [32*NUM_CH-1:0]         req_wdata,
    output logic [NUM_CH-1:0]            ack,
    output logic [31:0]                  rdata,
    output logic                         busy,
    output logic [CH_W-1:0]              grant_ch,
    input  logic [7:0]                   mem_din,
    output logic [7:0]                   mem_dout,
    output logic [ADDR_WIDTH-1:0]        mem_a,
    output logic                         mem_wr,
    input  logic                         io_buffer_full
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_ACK
    } state_t;

    state_t                r_state;
    logic [CH_W-1:0]       r_grantCh;
    logic [ADDR_WIDTH-1:0] r_baseAddr;
    logic [2:0]            r_nBytes;
    logic [2:0]            r_byteIdx;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdBuf;
    logic [31:0]           r_rdata;
`ifdef MEM_ARB_RR_EN
    logic [CH_W-1:0]       r_lastGrant;
`endif

    logic                  w_found;
    logic [CH_W-1:0]       w_selCh;
    logic                  w_selWr;
    logic [1:0]            w_selSize;
    logic [ADDR_WIDTH-1:0] w_selAddr;
    logic [31:0]           w_selWdata;
    int                    w_start;

    state_t                w_nextState;
    logic                  w_grant;
    logic                  w_capture;
    logic                  w_wrStrobe;
    logic [2:0]            w_idxNext;
    logic [ADDR_WIDTH-1:0] w_curAddr;
    logic [1:0]            w_capIdx;
    logic [31:0]           w_rdAssembled;

    function automatic logic [2:0] sizeToBytes(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Pick the requesting channel closest to the search start; start is 0 for fixed priority
    always_comb begin
        w_found    = 1'b0;
        w_selCh    = '0;
        w_selWr    = 1'b0;
        w_selSize  = '0;
        w_selAddr  = '0;
        w_selWdata = '0;
`ifdef MEM_ARB_RR_EN
        w_start    = (int'(r_lastGrant) + 1) % NUM_CH;
`else
        w_start    = 0;
`endif
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (req_valid[k] && ((pass == 0) ? (k < w_start) : (k >= w_start))) begin
                    w_found    = 1'b1;
                    w_selCh    = CH_W'(k);
                    w_selWr    = req_wr[k];
                    w_selSize  = req_size[2*k +: 2];
                    w_selAddr  = req_addr[ADDR_WIDTH*k +: ADDR_WIDTH];
                    w_selWdata = req_wdata[32*k +: 32];
                end
            end
        end
    end

    // Next state, memory port drive, ack pulse and datapath strobes
    always_comb begin
        w_nextState   = r_state;
        w_grant       = 1'b0;
        w_capture     = 1'b0;
        w_wrStrobe    = 1'b0;
        w_idxNext     = r_byteIdx;
        w_curAddr     = r_baseAddr + ADDR_WIDTH'(r_byteIdx);
        w_capIdx      = r_byteIdx[1:0] - 2'd1;
        w_rdAssembled = r_rdBuf;
        w_rdAssembled[{w_capIdx, 3'b000} +: 8] = mem_din;
        mem_a         = '0;
        mem_dout      = '0;
        ack           = '0;
        case (r_state)
            ST_IDLE: begin
                if (rdy_in && w_found && !flush) begin
                    w_grant = 1'b1;
                    mem_a   = w_selAddr;
                    if (w_selWr) begin
                        mem_dout = w_selWdata[7:0];
                        if (w_selAddr[17:16] == 2'b11 && io_buffer_full) begin
                            w_nextState = ST_WR;
                            w_idxNext   = 3'd0;
                        end else begin
                            w_wrStrobe  = 1'b1;
                            w_nextState = (sizeToBytes(w_selSize) == 3'd1) ? ST_ACK : ST_WR;
                            w_idxNext   = 3'd1;
                        end
                    end else begin
                        w_nextState = ST_RD;
                        w_idxNext   = 3'd1;
                    end
                end
            end
            ST_RD: begin
                if (flush) begin
                    w_nextState = ST_IDLE;
                    w_idxNext   = 3'd0;
                end else begin
                    w_capture = 1'b1;
                    if (r_byteIdx == r_nBytes) begin
                        w_nextState = ST_ACK;
                        w_idxNext   = 3'd0;
                    end else begin
                        mem_a     = w_curAddr;
                        w_idxNext = r_byteIdx + 3'd1;
                    end
                end
            end
            ST_WR: begin
                mem_a    = w_curAddr;
                mem_dout = r_wdata[{r_byteIdx[1:0], 3'b000} +: 8];
                if (!(w_curAddr[17:16] == 2'b11 && io_buffer_full)) begin
                    w_wrStrobe = 1'b1;
                    if (r_byteIdx == r_nBytes - 3'd1) begin
                        w_nextState = ST_ACK;
                        w_idxNext   = 3'd0;
                    end else begin
                        w_idxNext = r_byteIdx + 3'd1;
                    end
                end
            end
            ST_ACK: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (CH_W'(k) == r_grantCh) begin
                        ack[k] = rdy_in;
                    end
                end
                w_nextState = ST_IDLE;
                w_idxNext   = 3'd0;
            end
            default: begin
                w_nextState = ST_IDLE;
                w_idxNext   = 3'd0;
            end
        endcase
    end

    assign mem_wr   = w_wrStrobe && rdy_in;
    assign busy     = (r_state == ST_RD) || (r_state == ST_WR);
    assign grant_ch = r_grantCh;
    assign rdata    = r_rdata;

    // State register; a low rdy_in freezes the machine
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else if (rdy_in) begin
            r_state <= w_nextState;
        end
    end

    // Latch the granted request, step the byte index and assemble read bytes
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_grantCh  <= '0;
            r_baseAddr <= '0;
            r_nBytes   <= '0;
            r_byteIdx  <= '0;
            r_wdata    <= '0;
            r_rdBuf    <= '0;
            r_rdata    <= '0;
        end else if (rdy_in) begin
            r_byteIdx <= w_idxNext;
            if (w_grant) begin
                r_grantCh  <= w_selCh;
                r_baseAddr <= w_selAddr;
                r_nBytes   <= sizeToBytes(w_selSize);
                r_wdata    <= w_selWdata;
                r_rdBuf    <= '0;
            end
            if (w_capture) begin
                r_rdBuf <= w_rdAssembled;
                if (w_nextState == ST_ACK) begin
                    r_rdata <= w_rdAssembled;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember the last granted channel so the next search starts just past it
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_lastGrant <= CH_W'(NUM_CH - 1);
        end else if (rdy_in && w_grant) begin
            r_lastGrant <= w_selCh;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Stimulus pushes the
// expected acks and write strobes into queues; a monitor pops and compares
// whenever the DUT pulses ack or mem_wr. Honours MEM_ARB_RR_EN.
module tb_mem_arbiter;

    localparam int NUM_CH = 2;
    localparam int AW     = 32;
    localparam int CH_W   = 1;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic                   rdy_in;
    logic                   flush;
    logic [NUM_CH-1:0]      req_valid;
    logic [NUM_CH-1:0]      req_wr;
    logic [2*NUM_CH-1:0]    req_size;
    logic [AW*NUM_CH-1:0]   req_addr;
    logic [32*NUM_CH-1:0]   req_wdata;
    logic [NUM_CH-1:0]      ack;
    logic [31:0]            rdata;
    logic                   busy;
    logic [CH_W-1:0]        grant_ch;
    logic [7:0]             mem_din = 8'h00;
    logic [7:0]             mem_dout;
    logic [AW-1:0]          mem_a;
    logic                   mem_wr;
    logic                   io_buffer_full;

    typedef struct {
        int          ch;
        logic [31:0] data;
        bit          chk;
        int          cyc;
    } ackExp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wrExp_t;

    ackExp_t     ackQ[$];
    wrExp_t      wrQ[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  ram [0:1023];

    mem_arbiter #(
        .NUM_CH(NUM_CH),
        .ADDR_WIDTH(AW),
        .CH_W(CH_W)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .flush(flush),
        .req_valid(req_valid),
        .req_wr(req_wr),
        .req_size(req_size),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .ack(ack),
        .rdata(rdata),
        .busy(busy),
        .grant_ch(grant_ch),
        .mem_din(mem_din),
        .mem_dout(mem_dout),
        .mem_a(mem_a),
        .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // Free-running clock
    always #5 clk_in = ~clk_in;

    // Cycle counter used to time-stamp expectations
    always @(posedge clk_in) cyc <= cyc + 1;

    // Synchronous-read RAM; the whole system pauses with rdy_in
    always @(posedge clk_in) begin
        if (rdy_in) mem_din <= ram[mem_a[9:0]];
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int ch, input bit wr, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input int lat, input bit pushAck);
        req_wr[ch]              = wr;
        req_size[2*ch +: 2]     = size;
        req_addr[32*ch +: 32]   = addr;
        req_wdata[32*ch +: 32]  = wdata;
        req_valid[ch]           = 1'b1;
        if (pushAck) ackQ.push_back('{ch, expData, !wr, cyc + lat});
    endtask

    task automatic expectWrites(input logic [31:0] addr, input logic [31:0] data, input int n, input int startCyc);
        for (int i = 0; i < n; i++) begin
            wrQ.push_back('{addr + 32'(i), data[8*i +: 8], startCyc + i});
        end
    endtask

    task automatic waitAck(input int ch);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk_in);
            if (ack[ch]) seen = 1'b1;
        end
        checkOutput("ack arrives", 64'(seen), 64'd1);
        @(posedge clk_in);
        #1;
        req_valid[ch] = 1'b0;
    endtask

    // Monitor: pop and compare on every ack pulse and write strobe
    initial begin
        ackExp_t ea;
        wrExp_t  ew;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                if (ack != '0) begin
                    if (ackQ.size() == 0) begin
                        checkOutput("unexpected ack", 64'(ack), 64'd0);
                    end else begin
                        ea = ackQ.pop_front();
                        checkOutput("ack channel", 64'(ack), 64'(1) << ea.ch);
                        checkOutput("ack cycle", 64'(cyc), 64'(ea.cyc));
                        if (ea.chk) checkOutput("rdata", 64'(rdata), 64'(ea.data));
                    end
                end
                if (mem_wr) begin
                    if (wrQ.size() == 0) begin
                        checkOutput("unexpected write", 64'(mem_a), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ew = wrQ.pop_front();
                        checkOutput("write addr", 64'(mem_a), 64'(ew.addr));
                        checkOutput("write data", 64'(mem_dout), 64'(ew.data));
                        checkOutput("write cycle", 64'(cyc), 64'(ew.cyc));
                    end
                end
            end
        end
    end

    // Watchdog against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus sequence
    initial begin
        int n0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h34; ram[10'h101] = 8'h12;
        ram[10'h110] = 8'hA5; ram[10'h111] = 8'h5A; ram[10'h112] = 8'h77;
        ram[10'h113] = 8'h88; ram[10'h114] = 8'h99;
        ram[10'h120] = 8'hC1; ram[10'h121] = 8'hC2; ram[10'h122] = 8'hC3; ram[10'h123] = 8'hC4;
        ram[10'h300] = 8'h01; ram[10'h301] = 8'h02; ram[10'h302] = 8'h03; ram[10'h303] = 8'h04;

        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        req_valid = '0; req_wr = '0; req_size = '0; req_addr = '0; req_wdata = '0;

        @(negedge clk_in);
        checkOutput("reset ack", 64'(ack), 64'd0);
        checkOutput("reset rdata", 64'(rdata), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset grant_ch", 64'(grant_ch), 64'd0);
        checkOutput("reset mem_a", 64'(mem_a), 64'd0);
        checkOutput("reset mem_wr", 64'(mem_wr), 64'd0);
        checkOutput("reset mem_dout", 64'(mem_dout), 64'd0);
        @(posedge clk_in); #1; rst_in = 1'b0;
        @(posedge clk_in); #1;

        // Ch1 2-byte read at 0x100
        $display("[TB] ch1 2-byte read");
        applyStimulus(1, 1'b0, 2'd1, 32'h100, 32'h0, 32'h0000_1234, 3, 1'b1);
        @(negedge clk_in); checkOutput("read byte0 addr", 64'(mem_a), 64'h100);
        @(negedge clk_in); checkOutput("read byte1 addr", 64'(mem_a), 64'h101);
        waitAck(1);

        // Simultaneous 1-byte reads: ch0 first, ch1 the cycle after ch0's ack
        $display("[TB] simultaneous requests, round 1");
        applyStimulus(0, 1'b0, 2'd0, 32'h110, 32'h0, 32'h0000_00A5, 2, 1'b1);
        applyStimulus(1, 1'b0, 2'd0, 32'h111, 32'h0, 32'h0000_005A, 5, 1'b1);
        waitAck(0);
        waitAck(1);

        $display("[TB] ch0 alone");
        applyStimulus(0, 1'b0, 2'd0, 32'h112, 32'h0, 32'h0000_0077, 2, 1'b1);
        waitAck(0);

        $display("[TB] simultaneous requests, round 2");
`ifdef MEM_ARB_RR_EN
        applyStimulus(1, 1'b0, 2'd0, 32'h114, 32'h0, 32'h0000_0099, 2, 1'b1);
        applyStimulus(0, 1'b0, 2'd0, 32'h113, 32'h0, 32'h0000_0088, 5, 1'b1);
        waitAck(1);
        waitAck(0);
`else
        applyStimulus(0, 1'b0, 2'd0, 32'h113, 32'h0, 32'h0000_0088, 2, 1'b1);
        applyStimulus(1, 1'b0, 2'd0, 32'h114, 32'h0, 32'h0000_0099, 5, 1'b1);
        waitAck(0);
        waitAck(1);
`endif

        // Ch1 4-byte write at 0x200
        $display("[TB] ch1 4-byte write");
        applyStimulus(1, 1'b1, 2'd2, 32'h200, 32'hDEAD_BEEF, 32'h0, 4, 1'b1);
        expectWrites(32'h200, 32'hDEAD_BEEF, 4, cyc);
        waitAck(1);

        // IO write held off by a full UART buffer for 5 cycles
        $display("[TB] io write with buffer full");
        io_buffer_full = 1'b1;
        applyStimulus(1, 1'b1, 2'd0, 32'h3_0000, 32'h0000_0041, 32'h0, 6, 1'b1);
        expectWrites(32'h3_0000, 32'h0000_0041, 1, cyc + 5);
        repeat (2) @(negedge clk_in);
        checkOutput("io stall mem_wr", 64'(mem_wr), 64'd0);
        checkOutput("io stall mem_a", 64'(mem_a), 64'h3_0000);
        checkOutput("io stall busy", 64'(busy), 64'd1);
        repeat (4) @(posedge clk_in);
        #1; io_buffer_full = 1'b0;
        waitAck(1);

        // Flush aborts a 4-byte read in its cycle 2
        $display("[TB] flush during read");
        applyStimulus(0, 1'b0, 2'd2, 32'h120, 32'h0, 32'h0, 0, 1'b0);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1; flush = 1'b1; req_valid[0] = 1'b0;
        @(negedge clk_in); checkOutput("busy before abort", 64'(busy), 64'd1);
        @(posedge clk_in); #1; flush = 1'b0;
        @(negedge clk_in);
        checkOutput("busy after abort", 64'(busy), 64'd0);
        checkOutput("mem_a after abort", 64'(mem_a), 64'd0);
        repeat (4) @(posedge clk_in);
        #1;

        // Same flush pulse during a write is ignored
        $display("[TB] flush during write");
        n0 = cyc;
        applyStimulus(1, 1'b1, 2'd2, 32'h210, 32'h1122_3344, 32'h0, 4, 1'b1);
        expectWrites(32'h210, 32'h1122_3344, 4, n0);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1; flush = 1'b1;
        @(posedge clk_in); #1; flush = 1'b0;
        waitAck(1);

        // rdy_in low for 3 cycles after byte 1 of a 4-byte read
        $display("[TB] rdy pause during read");
        applyStimulus(1, 1'b0, 2'd2, 32'h300, 32'h0, 32'h0403_0201, 8, 1'b1);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1; rdy_in = 1'b0;
        @(negedge clk_in);
        checkOutput("pause mem_a", 64'(mem_a), 64'h303);
        checkOutput("pause mem_wr", 64'(mem_wr), 64'd0);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        checkOutput("pause mem_a held", 64'(mem_a), 64'h303);
        checkOutput("pause busy", 64'(busy), 64'd1);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1; rdy_in = 1'b1;
        waitAck(1);

        repeat (5) @(posedge clk_in);
        #1;
        checkOutput("ack queue drained", 64'(ackQ.size()), 64'd0);
        checkOutput("write queue drained", 64'(wrQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised successor to the two-requester (IF / SLB) memory mux in the CPU top.
- Serialises NUM_CH independent 1/2/4-byte read/write requests onto the single 8-bit RAM/IO port.
- Assembles multi-byte reads and splits multi-byte writes, little-endian.
- Honours flush (control_hazard), rdy_in pause and io_buffer_full back-pressure. Replaces the ad-hoc IF_access_valid / slb_access_valid logic.

Parameters:
- NUM_CH, 2, number of requesting channels; channel 0 is the highest fixed priority.
- ADDR_WIDTH, 32, request and memory address width.
- CH_W, 1, width of the granted-channel index; must be at least clog2(NUM_CH).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  global ready; low freezes all state
- flush  in  1  control_hazard; cancels an in-flight read
- req_valid  in  NUM_CH  per-channel request; held until ack
- req_wr  in  NUM_CH  1 = write, 0 = read
- req_size  in  2*NUM_CH  per channel: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes (3 treated as 4)
- req_addr  in  ADDR_WIDTH*NUM_CH  per-channel byte address
- req_wdata  in  32*NUM_CH  per-channel write data, little-endian
- ack  out  NUM_CH  one-cycle done pulse, one-hot
- rdata  out  32  read result, valid with ack; zero-extended
- busy  out  1  transfer in progress
- grant_ch  out  CH_W  channel being served
- mem_din  in  8  RAM/IO read byte; valid the cycle after its address
- mem_dout  out  8  write byte
- mem_a  out  ADDR_WIDTH  byte address
- mem_wr  out  1  write strobe
- io_buffer_full  in  1  UART buffer full

Behaviour:
- Reset (asynchronous, rst_in high): state IDLE; ack = 0, rdata = 0, busy = 0, grant_ch = 0, mem_a = 0, mem_dout = 0, mem_wr = 0, byte counters = 0.
- rdy_in low: no register changes. mem_wr is forced to 0 combinationally. ack is held at 0.
- States:
  - IDLE: if any req_valid and !flush, grant per arbitration; latch addr, size, wr, wdata; nbytes = size+1 (4 for size ≥ 2). Go to RD or WR. mem_a/mem_dout/mem_wr are driven in the same cycle for byte 0.
  - RD: byte i address driven in cycle i (i = 0..n-1). mem_din captured into rdata[8i+7:8i] in cycle i+1. After the last capture go to ACK.
  - WR: byte i driven with mem_wr = 1 in cycle i. After byte n-1 go to ACK.
  - ACK: ack[grant_ch] = 1 for exactly one cycle, busy = 0, return to IDLE. No new grant in the ACK cycle.
- Latency, grant cycle = 0, no stalls:
  - read of n bytes: ack in cycle n+1;
  - write of n bytes: ack in cycle n.
- Addresses increment by 1 per byte, mod 2^ADDR_WIDTH; no alignment requirement.
- IO space is mem_a[17:16] == 2'b11:
  - writes: while io_buffer_full = 1, mem_wr = 0 and the byte index holds; the byte is issued the first cycle io_buffer_full = 0;
  - reads: not stalled.
- Flush:
  - during RD: abort immediately, mem_wr = 0, no ack, next state IDLE, partial rdata discarded;
  - during WR or ACK: ignored; the write completes and is acked;
  - in IDLE: suppresses granting that cycle.
- Requesters must drop req_valid in the cycle after ack, or present a new request; a still-high req_valid is a new request.
- rdata holds its last value between acks. Size-1 and size-2 reads zero the upper bytes.
- Reset asserted mid-transfer aborts immediately with no ack.
- When mem_wr = 0 and no transfer is active, mem_a = 0.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. Search starts at (last_grant+1) mod NUM_CH; last_grant is reset to NUM_CH-1.
- Undefined: fixed priority, lowest index wins.
- All latencies are identical in both modes.

Test Plan:
- Ch1 read, size 2, addr 0x100, RAM[0x100..0x101] = 0x34,0x12 -> mem_a 0x100 then 0x101; ack[1] in cycle 3; rdata = 0x00001234.
- Ch0 and ch1 both request 1-byte reads on the same cycle -> fixed: ch0 acked first, ch1 granted the cycle after ch0's ack. With MEM_ARB_RR_EN, the second round after ch0 again requests serves ch1 first.
- Ch1 write, size 4, addr 0x200, wdata 0xDEADBEEF -> mem_wr bytes EF,BE,AD,DE at 0x200..0x203 on cycles 0-3; ack[1] in cycle 4.
- Ch1 write, size 1, addr 0x30000, data 0x41, io_buffer_full high 5 cycles -> mem_wr stays 0 for 5 cycles, then one strobe with mem_dout = 0x41; ack one cycle later.
- Ch0 4-byte read, flush in cycle 2 -> no ack, busy = 0 next cycle. The same flush pulse during a ch1 4-byte write leaves all 4 bytes written and acked.
- rdy_in low 3 cycles mid-read (after byte 1) -> mem_wr = 0, state and mem_a frozen; ack delayed by exactly 3 cycles; rdata correct.
